// File: rtl/popcount_frame_acc_if.sv
// Handshake bundle for popcount_frame_acc: start, per-beat count input and frame-total output.
// master drives the block's inputs; slave is the accumulator side.
interface popcount_frame_acc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             in_valid;
  logic [1:0]       in_cnt;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, in_valid, in_cnt, out_ready,
    input  in_ready, out_valid, out_sum, busy, ovf
  );

  modport slave (
    input  start, in_valid, in_cnt, out_ready,
    output in_ready, out_valid, out_sum, busy, ovf
  );
endinterface

// File: rtl/popcount_frame_acc.sv
// Frame accumulator for 2-bit popcount beats: sums FRAME_LEN beats and holds the total.
// Define POPACC_SAT_EN to saturate the accumulator instead of wrapping modulo 2^WIDTH.
module popcount_frame_acc #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_frame_acc_if.slave  bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_p1;
  logic             ovf_p1;
  logic [CNT_W-1:0] beat_q;
  logic             beat_fire;
  logic             clear;
  logic [WIDTH:0]   sum_p0;

  // One bit of headroom so the carry out of the top accumulator bit is visible.
  function automatic logic [WIDTH:0] add_beat(input logic [WIDTH-1:0] acc,
                                               input logic [1:0]       cnt);
    return {1'b0, acc} + {{(WIDTH-1){1'b0}}, cnt};
  endfunction

  function automatic logic [WIDTH-1:0] limit_sum(input logic [WIDTH:0] sum);
`ifdef POPACC_SAT_EN
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    return sum[WIDTH-1:0];
`endif
  endfunction

  assign beat_fire = (state_q == ACCUM) && bus.in_valid;
  assign clear     = (state_q == IDLE) && bus.start;
  assign sum_p0    = add_beat(acc_p1, bus.in_cnt);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (bus.in_valid && (beat_q == LAST_BEAT)) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Beat stage: running sum, sticky overflow and beat count register here.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_p1 <= '0;
      ovf_p1 <= 1'b0;
      beat_q <= '0;
    end else if (beat_fire) begin
      acc_p1 <= limit_sum(sum_p0);
      ovf_p1 <= ovf_p1 | sum_p0[WIDTH];
      beat_q <= beat_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = acc_p1;
  assign bus.ovf       = ovf_p1;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Bench for popcount_frame_acc: directed frames plus random frames checked against a frame-sum model.
module tb_popcount_frame_acc;

  localparam int WA = 8;
  localparam int FA = 4;
  localparam int WB = 4;
  localparam int FB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   beats[$];

  always #5 clk = ~clk;

  popcount_frame_acc_if #(.WIDTH(WA)) ifa ();
  popcount_frame_acc_if #(.WIDTH(WB)) ifb ();

  popcount_frame_acc #(.WIDTH(WA), .FRAME_LEN(FA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  popcount_frame_acc #(.WIDTH(WB), .FRAME_LEN(FB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Expected frame total for a raw arithmetic sum at a given accumulator width.
  function automatic int model_sum(input int total, input int w);
    int maxv;
    maxv = (1 << w) - 1;
`ifdef POPACC_SAT_EN
    return (total > maxv) ? maxv : total;
`else
    return total % (1 << w);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = in_valid always high, 1 = alternating 1,0,..., 2 = random.
  task automatic run_a(input int mode, input int hold_cycles,
                       input bit start_in_accum, input bit start_in_hold);
    int idx;
    int running;
    int total;
    int exp_sum;
    bit exp_ovf;
    total = 0;
    foreach (beats[i]) total += beats[i];
    exp_sum = model_sum(total, WA);
    exp_ovf = (total > (1 << WA) - 1);

    ifa.out_ready = (hold_cycles == 0 && !start_in_hold);
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    check("a_start_in_ready", 32'(ifa.in_ready), 32'd1);
    check("a_start_sum_clear", 32'(ifa.out_sum), 32'd0);

    idx = 0;
    running = 0;
    for (int cyc = 0; cyc < 200 && idx < FA; cyc++) begin
      case (mode)
        0:       ifa.in_valid = 1'b1;
        1:       ifa.in_valid = (cyc % 2 == 0);
        default: ifa.in_valid = 1'($urandom_range(0, 1));
      endcase
      ifa.in_cnt = 2'(beats[idx]);
      ifa.start = start_in_accum && (cyc == 1);
      if (ifa.in_valid) begin
        running += beats[idx];
        idx++;
      end
      step();
      ifa.start = 1'b0;
      if (idx < FA) begin
        check("a_accum_out_valid", 32'(ifa.out_valid), 32'd0);
        check("a_accum_in_ready", 32'(ifa.in_ready), 32'd1);
        check("a_running_sum", 32'(ifa.out_sum), 32'(model_sum(running, WA)));
      end
    end
    ifa.in_valid = 1'b0;
    check("a_frame_done", 32'(idx), 32'(FA));
    check("a_hold_out_valid", 32'(ifa.out_valid), 32'd1);
    check("a_hold_sum", 32'(ifa.out_sum), 32'(exp_sum));
    check("a_hold_ovf", 32'(ifa.ovf), 32'(exp_ovf));
    check("a_hold_in_ready", 32'(ifa.in_ready), 32'd0);

    for (int h = 0; h < hold_cycles; h++) begin
      step();
      check("a_bp_out_valid", 32'(ifa.out_valid), 32'd1);
      check("a_bp_sum", 32'(ifa.out_sum), 32'(exp_sum));
      check("a_bp_in_ready", 32'(ifa.in_ready), 32'd0);
    end

    ifa.out_ready = 1'b1;
    ifa.start = start_in_hold;
    step();
    ifa.out_ready = 1'b0;
    ifa.start = 1'b0;
    check("a_idle_out_valid", 32'(ifa.out_valid), 32'd0);
    check("a_idle_busy", 32'(ifa.busy), 32'd0);
    check("a_idle_sum_kept", 32'(ifa.out_sum), 32'(exp_sum));
    if (start_in_hold) begin
      step();
      check("a_no_restart_busy", 32'(ifa.busy), 32'd0);
      check("a_no_restart_in_ready", 32'(ifa.in_ready), 32'd0);
      check("a_no_restart_sum", 32'(ifa.out_sum), 32'(exp_sum));
    end
  endtask

  initial begin
    int total_b;
    ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_cnt = 2'd0; ifa.out_ready = 1'b0;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_cnt = 2'd0; ifb.out_ready = 1'b0;

    // Reset held for two cycles, outputs all zero.
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step();
      check("rst_in_ready", 32'(ifa.in_ready), 32'd0);
      check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
      check("rst_out_sum", 32'(ifa.out_sum), 32'd0);
      check("rst_busy", 32'(ifa.busy), 32'd0);
      check("rst_ovf", 32'(ifa.ovf), 32'd0);
      check("rst_b_busy", 32'(ifb.busy), 32'd0);
    end
    rst = 1'b0;
    step();
    check("idle_no_start_in_ready", 32'(ifa.in_ready), 32'd0);

    // Basic frame 3,1,0,2.
    beats = '{3, 1, 0, 2};
    run_a(0, 0, 1'b0, 1'b0);

    // Same frame with alternating in_valid and 3 cycles of backpressure.
    run_a(1, 3, 1'b0, 1'b0);

    // start pulsed in ACCUM, then together with out_ready in HOLD.
    beats = '{2, 3, 3, 1};
    run_a(0, 1, 1'b1, 1'b1);

    // Reset after 2 of 4 beats discards the frame.
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_cnt = 2'd3;
    step();
    step();
    ifa.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("midrst_busy", 32'(ifa.busy), 32'd0);
    check("midrst_sum", 32'(ifa.out_sum), 32'd0);
    step();
    check("midrst_stays_idle", 32'(ifa.out_valid), 32'd0);
    beats = '{1, 1, 1, 1};
    run_a(0, 0, 1'b0, 1'b0);

    // Overflow frame on the narrow instance: eight beats of 3.
    total_b = 0;
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.in_cnt = 2'd3;
    for (int i = 0; i < FB; i++) begin
      check("b_no_early_valid", 32'(ifb.out_valid), 32'd0);
      step();
      total_b += 3;
    end
    ifb.in_valid = 1'b0;
    check("b_ovf_out_valid", 32'(ifb.out_valid), 32'd1);
    check("b_ovf_sum", 32'(ifb.out_sum), 32'(model_sum(total_b, WB)));
    check("b_ovf_flag", 32'(ifb.ovf), 32'(total_b > (1 << WB) - 1));
    ifb.out_ready = 1'b1;
    step();
    ifb.out_ready = 1'b0;
    check("b_ovf_idle", 32'(ifb.busy), 32'd0);

    // Random frames with random stalls and backpressure.
    for (int f = 0; f < 20; f++) begin
      beats.delete();
      for (int i = 0; i < FA; i++) beats.push_back(int'($urandom_range(0, 3)));
      run_a(2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
